// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame controller: fetches GRB words from pixel RAM and feeds a free-running
// RZ encoder, gating the LED line so that it is only enabled over whole words.
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS  = 64,
  parameter int ADDR_W    = 6,
  parameter int BIT_CYC   = 63,
  parameter int LATCH_CYC = 15000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       rgb,
  input  logic              tx_done,
  output logic              enc_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0]  MAX_LEN    = (ADDR_W+1)'(NUM_LEDS);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC);

  typedef enum logic [2:0] {
    IDLE, FETCH0, ALIGN, SEND, TAIL, LATCH, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ph_q, ph_d;
  logic              rd_valid_q, rd_valid_d;
  logic [23:0]       nxt_q, nxt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              enc_en_q, enc_en_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [ADDR_W:0]   len_fit_s;
  logic [ADDR_W:0]   words_inc_s;
  logic [ADDR_W:0]   addr_inc_s;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_d      = words_q;
    cnt_d        = cnt_q;
    ph_d         = ph_q;
    rd_valid_d   = rd_en_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rgb_d        = rgb_q;
    enc_en_d     = enc_en_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    len_fit_s   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    words_inc_s = words_q + (ADDR_W+1)'(1);
    addr_inc_s  = {1'b0, rd_addr_q} + (ADDR_W+1)'(1);

    // The first word goes straight to rgb in FETCH0; later reads land in the prefetch slot.
    if (rd_valid_q && (state_q != FETCH0)) begin
      nxt_d = rd_data;
    end else begin
      nxt_d = nxt_q;
    end

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          if (frame_len == '0) begin
            len_d        = '0;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            len_d     = len_fit_s;
            words_d   = '0;
            ph_d      = 1'b0;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            state_d   = FETCH0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      FETCH0: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d    = 1'b0;
          rgb_d   = rd_data;
          cnt_d   = '0;
          state_d = ALIGN;
          if (len_q > (ADDR_W+1)'(1)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(1'b1);
          end else begin
            rd_en_d = 1'b0;
          end
        end
      end

      // cnt_q == 0 means still waiting for a word boundary marker from the encoder.
      ALIGN: begin
        if (cnt_q == '0) begin
          if (tx_done) begin
            cnt_d = CNT_W'(1'b1);
          end else begin
            cnt_d = cnt_q;
          end
        end else if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          enc_en_d = 1'b1;
          state_d  = SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end

      SEND: begin
        if (tx_done) begin
          if (words_inc_s < len_q) begin
            rgb_d   = nxt_q;
            words_d = words_inc_s;
            if (addr_inc_s < len_q) begin
              rd_en_d   = 1'b1;
              rd_addr_d = rd_addr_q + ADDR_W'(1'b1);
            end else begin
              rd_en_d = 1'b0;
            end
          end else begin
            cnt_d   = CNT_W'(1'b1);
            state_d = TAIL;
          end
        end else begin
          state_d = SEND;
        end
      end

      // Keep the line enabled while the encoder shifts out bit 0 of the last word.
      TAIL: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          enc_en_d = 1'b0;
          state_d  = LATCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end

      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d        = '0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        enc_en_d = 1'b0;
        busy_d   = 1'b0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and gates the line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      words_q      <= '0;
      cnt_q        <= '0;
      ph_q         <= 1'b0;
      rd_valid_q   <= 1'b0;
      nxt_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rgb_q        <= '0;
      enc_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_q      <= words_d;
      cnt_q        <= cnt_d;
      ph_q         <= ph_d;
      rd_valid_q   <= rd_valid_d;
      nxt_q        <= nxt_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rgb_q        <= rgb_d;
      enc_en_q     <= enc_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign rgb        = rgb_q;
  assign enc_en     = enc_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Scoreboard bench for ws2812_frame_ctrl: a free-running RZ encoder and pixel RAM model,
// expected reads/words/windows queued by the stimulus and popped by a negedge monitor.
module tb_ws2812_frame_ctrl;

  localparam int NL  = 64;
  localparam int AW  = 6;
  localparam int BC  = 6;
  localparam int LC  = 40;
  localparam int T0H = BC / 3;
  localparam int T1H = (2 * BC) / 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   frame_len;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data = 24'h0;
  logic [23:0]   rgb;
  logic          tx_done;
  logic          enc_en;
  logic          busy;
  logic          frame_done;

  logic [23:0] mem [NL];
  int          e_cyc = 0;
  int          e_bit = 23;
  logic [23:0] e_sh = 24'h0;
  logic        line;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  int          exp_addr_q[$];
  logic [23:0] exp_word_q[$];
  int          exp_en_q[$];
  int          exp_fd_q[$];

  int          start_cyc = 0;
  int          fall_cyc = 0;
  int          en_run = 0;
  int          hi_run = 0;
  int          nbits = 0;
  int          mon_k = 0;
  bit          en_prev = 1'b0;
  logic [23:0] bits = 24'h0;

  ws2812_frame_ctrl #(
    .NUM_LEDS(NL), .ADDR_W(AW), .BIT_CYC(BC), .LATCH_CYC(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rgb(rgb),
    .tx_done(tx_done), .enc_en(enc_en), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en === 1'b1) rd_data <= mem[rd_addr];
  end

  // Free-running encoder: MSB first, latches rgb at each word start, marks bit 0.
  always @(posedge clk) begin
    if (e_cyc == BC - 1) begin
      e_cyc <= 0;
      if (e_bit == 0) begin
        e_bit <= 23;
        e_sh  <= rgb;
      end else begin
        e_bit <= e_bit - 1;
      end
    end else begin
      e_cyc <= e_cyc + 1;
    end
  end

  assign tx_done = (e_bit == 0) && (e_cyc == 0);
  assign line    = (enc_en === 1'b1) && (e_sh[e_bit] ? (e_cyc < T1H) : (e_cyc < T0H));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a read, a line word, a window or a done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (start === 1'b1) start_cyc = cyc;
      if (mon_on) begin
        if (rd_en === 1'b1) begin
          chk("busy_during_read", busy, 1);
          chk("read_expected", exp_addr_q.size() > 0, 1);
          if (exp_addr_q.size() > 0) chk("rd_addr", rd_addr, exp_addr_q.pop_front());
        end
        if (enc_en === 1'b1) begin
          en_run++;
        end else if (en_prev) begin
          fall_cyc = cyc;
          chk("en_window_expected", exp_en_q.size() > 0, 1);
          if (exp_en_q.size() > 0) chk("enc_en_cycles", en_run, exp_en_q.pop_front());
          en_run = 0;
        end
        en_prev = (enc_en === 1'b1);
        if (line) begin
          hi_run++;
        end else if (hi_run > 0) begin
          bits   = {bits[22:0], (hi_run > BC / 2)};
          nbits++;
          hi_run = 0;
          if (nbits == 24) begin
            chk("word_expected", exp_word_q.size() > 0, 1);
            if (exp_word_q.size() > 0) chk("line_word", bits, exp_word_q.pop_front());
            nbits = 0;
          end
        end
      end else begin
        en_run  = 0;
        en_prev = 1'b0;
        hi_run  = 0;
        nbits   = 0;
      end
      if (frame_done === 1'b1) begin
        chk("busy_low_at_done", busy, 0);
        chk("frame_done_expected", exp_fd_q.size() > 0, 1);
        if (exp_fd_q.size() > 0) begin
          mon_k = exp_fd_q.pop_front();
          if (mon_k == 0) chk("done_after_start", cyc - start_cyc, 1);
          else            chk("done_after_latch", cyc - fall_cyc, LC + 1);
        end
      end
    end
  end

  // Every reset assertion must clear all outputs immediately.
  always @(negedge rst_n) begin
    #1;
    chk("reset_outputs", {busy, enc_en, frame_done, rd_en, rd_addr, rgb}, 64'd0);
  end

  function automatic int eff_len(input int flen);
    return (flen > NL) ? NL : flen;
  endfunction

  function automatic int budget_for(input int flen);
    return eff_len(flen) * 24 * BC + 3 * 24 * BC + LC + 50;
  endfunction

  task automatic push_frame(input int flen);
    int n;
    n = eff_len(flen);
    if (n == 0) begin
      exp_fd_q.push_back(0);
    end else begin
      for (int a = 0; a < n; a++) begin
        exp_addr_q.push_back(a);
        exp_word_q.push_back(mem[a]);
      end
      exp_en_q.push_back(n * 24 * BC);
      exp_fd_q.push_back(1);
    end
  endtask

  task automatic pulse_start(input int flen);
    @(posedge clk); #1;
    frame_len = (AW+1)'(flen);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (frame_done === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic wait_enc(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (enc_en === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) chk("enc_en_timeout", 0, 1);
  endtask

  task automatic run_frame(input int flen);
    push_frame(flen);
    pulse_start(flen);
    wait_done(budget_for(flen));
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("reads_drained", exp_addr_q.size(), 0);
    chk("words_drained", exp_word_q.size(), 0);
    chk("windows_drained", exp_en_q.size(), 0);
    chk("dones_drained", exp_fd_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    for (int i = 0; i < NL; i++) mem[i] = {i[7:0], 8'hA5 ^ i[7:0], 8'h3C + i[7:0]};
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00FF00;
    mem[2] = 24'h0000FF;

    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    run_frame(3);   drain();
    run_frame(1);   drain();
    run_frame(0);   drain();
    run_frame(100); drain();

    // Starts while busy and in the frame_done cycle must not launch another frame.
    push_frame(2);
    pulse_start(2);
    repeat (5) @(posedge clk);
    pulse_start(5);
    wait_enc(40 * BC);
    pulse_start(7);
    wait_done(budget_for(2));
    frame_len = (AW+1)'(3);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    repeat (30 * BC) @(posedge clk);
    drain();

    // Abort mid-SEND, then a full normal frame.
    mon_on = 1'b0;
    pulse_start(3);
    wait_enc(budget_for(3));
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (LC + 100) @(posedge clk);
    #1;
    mon_on = 1'b1;
    run_frame(3); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
